// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational; resolved branches from execute train the table at
// the next rising edge. Defining BP_STATS_EN adds saturating counters of
// resolved updates and of reported mispredicts.
module branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int IDX_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PC,
   output logic                  predict_taken,
   output logic [DATA_WIDTH-1:0] branch_target,
   input  logic                  upd_valid,
   input  logic [DATA_WIDTH-1:0] upd_PC,
   input  logic [DATA_WIDTH-1:0] upd_target,
   input  logic                  upd_taken,
   input  logic                  upd_mispredict,
   input  logic                  bp_clear
`ifdef BP_STATS_EN
   ,
   output logic [31:0]           stat_branches,
   output logic [31:0]           stat_mispredicts
`endif
);

   localparam int ENTRIES = 2 ** IDX_BITS;
   localparam int TAG_W   = DATA_WIDTH - IDX_BITS - 2;

   // Counter encoding: 00 strongly not taken .. 11 strongly taken.
   localparam logic [1:0] CTR_WNT = 2'b01;
   localparam logic [1:0] CTR_WT  = 2'b10;

   function automatic logic [1:0] ctr_up(input logic [1:0] c);
      return (c == 2'b11) ? c : c + 2'b01;
   endfunction

   function automatic logic [1:0] ctr_down(input logic [1:0] c);
      return (c == 2'b00) ? c : c - 2'b01;
   endfunction

   logic                  tbl_valid  [ENTRIES];
   logic [TAG_W-1:0]      tbl_tag    [ENTRIES];
   logic [DATA_WIDTH-1:0] tbl_target [ENTRIES];
   logic [1:0]            tbl_ctr    [ENTRIES];

   logic [IDX_BITS-1:0] look_idx;
   logic [TAG_W-1:0]    look_tag;
   logic                look_hit;
   logic [IDX_BITS-1:0] upd_idx;
   logic [TAG_W-1:0]    upd_tag;
   logic                upd_hit;

   // The two low PC bits never select an entry (word-aligned fetch).
   logic unused_bits;
   assign unused_bits = ^{PC[1:0], upd_PC[1:0]};

   assign look_idx = PC[IDX_BITS+1:2];
   assign look_tag = PC[DATA_WIDTH-1:IDX_BITS+2];
   assign upd_idx  = upd_PC[IDX_BITS+1:2];
   assign upd_tag  = upd_PC[DATA_WIDTH-1:IDX_BITS+2];

   // Fetch-side lookup: zero latency, reads the contents as of the last edge.
   always_comb begin
      predict_taken = 1'b0;
      branch_target = '0;
      look_hit      = tbl_valid[look_idx] && (tbl_tag[look_idx] == look_tag);
      if (look_hit) begin
         predict_taken = tbl_ctr[look_idx][1];
         branch_target = tbl_target[look_idx];
      end
   end

   // Hit detection for the resolved instruction, against pre-update contents.
   always_comb begin
      upd_hit = tbl_valid[upd_idx] && (tbl_tag[upd_idx] == upd_tag);
   end

   // Table training; clear outranks a simultaneous update, and a not-taken
   // miss is deliberately not allocated so cold branches stay out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_valid[i]  <= 1'b0;
            tbl_tag[i]    <= '0;
            tbl_target[i] <= '0;
            tbl_ctr[i]    <= CTR_WNT;
         end
      end else if (bp_clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            tbl_valid[i] <= 1'b0;
         end
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               tbl_ctr[upd_idx]    <= ctr_up(tbl_ctr[upd_idx]);
               tbl_target[upd_idx] <= upd_target;
            end else begin
               tbl_ctr[upd_idx] <= ctr_down(tbl_ctr[upd_idx]);
            end
         end else if (upd_taken) begin
            tbl_valid[upd_idx]  <= 1'b1;
            tbl_tag[upd_idx]    <= upd_tag;
            tbl_target[upd_idx] <= upd_target;
            tbl_ctr[upd_idx]    <= CTR_WT;
         end
      end
   end

`ifdef BP_STATS_EN
   function automatic logic [31:0] stat_up(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Event counters; independent of bp_clear so flushes do not lose history.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else if (upd_valid) begin
         stat_branches <= stat_up(stat_branches);
         if (upd_mispredict) begin
            stat_mispredicts <= stat_up(stat_mispredicts);
         end
      end
   end
`else
   // Mispredict reports only feed the statistics counters.
   logic unused_mispredict;
   assign unused_mispredict = upd_mispredict;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: the driver pushes the expected lookup
// result from a table-of-records reference model; a monitor pops and compares.
module tb_branch_predictor;
   localparam int DW  = 32;
   localparam int IB  = 4;
   localparam int ENT = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] PC;
   logic          predict_taken;
   logic [DW-1:0] branch_target;
   logic          upd_valid;
   logic [DW-1:0] upd_PC;
   logic [DW-1:0] upd_target;
   logic          upd_taken;
   logic          upd_mispredict;
   logic          bp_clear;
`ifdef BP_STATS_EN
   logic [31:0]   stat_branches;
   logic [31:0]   stat_mispredicts;
`endif

   always #5 clk = ~clk;

   branch_predictor #(.DATA_WIDTH(DW), .IDX_BITS(IB)) dut (
      .clk            (clk),
      .rst            (rst),
      .PC             (PC),
      .predict_taken  (predict_taken),
      .branch_target  (branch_target),
      .upd_valid      (upd_valid),
      .upd_PC         (upd_PC),
      .upd_target     (upd_target),
      .upd_taken      (upd_taken),
      .upd_mispredict (upd_mispredict),
      .bp_clear       (bp_clear)
`ifdef BP_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   typedef struct {
      logic        taken;
      logic [31:0] target;
      logic [31:0] br;
      logic [31:0] mp;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: one record per slot holding the full word address of
   // the branch that owns it and a direction strength 0..3.
   bit          m_valid [ENT];
   logic [29:0] m_line  [ENT];
   logic [31:0] m_tgt   [ENT];
   int          m_str   [ENT];
   logic [31:0] m_br;
   logic [31:0] m_mp;

   function automatic int slot_of(input logic [31:0] a);
      return int'((a >> 2) % ENT);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENT; i++) begin
         m_valid[i] = 1'b0;
         m_line[i]  = '0;
         m_tgt[i]   = '0;
         m_str[i]   = 1;
      end
      m_br = '0;
      m_mp = '0;
   endtask

   task automatic push_expect();
      exp_t e;
      int   s;
      s = slot_of(PC);
      e.taken  = 1'b0;
      e.target = '0;
      if (m_valid[s] && m_line[s] == PC[31:2]) begin
         e.taken  = (m_str[s] >= 2);
         e.target = m_tgt[s];
      end
      e.br = m_br;
      e.mp = m_mp;
      sbq.push_back(e);
   endtask

   task automatic model_apply();
      int s;
      if (upd_valid) begin
         if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
         if (upd_mispredict && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
      end
      if (bp_clear) begin
         for (int i = 0; i < ENT; i++) m_valid[i] = 1'b0;
      end else if (upd_valid) begin
         s = slot_of(upd_PC);
         if (m_valid[s] && m_line[s] == upd_PC[31:2]) begin
            if (upd_taken) begin
               m_str[s] = (m_str[s] < 3) ? m_str[s] + 1 : 3;
               m_tgt[s] = upd_target;
            end else begin
               m_str[s] = (m_str[s] > 0) ? m_str[s] - 1 : 0;
            end
         end else if (upd_taken) begin
            m_valid[s] = 1'b1;
            m_line[s]  = upd_PC[31:2];
            m_tgt[s]   = upd_target;
            m_str[s]   = 2;
         end
      end
   endtask

   task automatic cycle(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic [31:0] tgt, input logic tk, input logic mp,
                        input logic clr);
      @(posedge clk);
      #1;
      PC             = pc;
      upd_valid      = uv;
      upd_PC         = upc;
      upd_target     = tgt;
      upd_taken      = tk;
      upd_mispredict = mp;
      bp_clear       = clr;
      push_expect();
      model_apply();
   endtask

   task automatic idle(input logic [31:0] pc);
      cycle(pc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   function automatic logic [31:0] rnd_pc();
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(0, 7) != 0)
         p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
      return p;
   endfunction

   task automatic random_cycles(input int n);
      logic [31:0] pc;
      for (int k = 0; k < n; k++) begin
         pc = rnd_pc();
         cycle(pc, ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 3) == 0) ? pc : rnd_pc(),
               $urandom, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 39) == 0));
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: one expectation per driven cycle, compared mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check("predict_taken", {31'b0, predict_taken}, {31'b0, e.taken});
         check("branch_target", branch_target, e.target);
`ifdef BP_STATS_EN
         check("stat_branches", stat_branches, e.br);
         check("stat_mispredicts", stat_mispredicts, e.mp);
`endif
      end
   end

   initial begin
      #500000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached with %0d pending", sbq.size());
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst            = 1'b0;
      PC             = '0;
      upd_valid      = 1'b0;
      upd_PC         = '0;
      upd_target     = '0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
      bp_clear       = 1'b0;
      model_reset();

      // Lookups while reset is held
      idle(32'h100);
      idle(32'h100);
      #6 rst = 1'b1;

      // Cold lookup, allocate, no same-cycle bypass, then hit
      idle(32'h100);
      cycle(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
      idle(32'h100);
      // Two not-taken updates: 10 -> 01 -> 00, target kept
      cycle(32'h100, 1'b1, 32'h100, 32'h999, 1'b0, 1'b1, 1'b0);
      cycle(32'h100, 1'b1, 32'h100, 32'h999, 1'b0, 1'b0, 1'b0);
      idle(32'h100);
      // Alias at the same slot with a different tag
      idle(32'h140);
      // Saturation at 11 and target overwrite
      for (int k = 0; k < 5; k++) cycle(32'h100, 1'b1, 32'h100, 32'h240 + 32'(k), 1'b1, 1'b0, 1'b0);
      cycle(32'h100, 1'b1, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
      idle(32'h100);
      // Not-taken miss must not allocate
      cycle(32'h300, 1'b1, 32'h300, 32'h500, 1'b0, 1'b0, 1'b0);
      idle(32'h300);
      // Clear outranks a simultaneous taken update
      cycle(32'h100, 1'b1, 32'h300, 32'h400, 1'b1, 1'b0, 1'b1);
      idle(32'h100);
      idle(32'h300);

      random_cycles(400);

      // Reset asserted mid-update: outputs drop at once and the update is lost
      cycle(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      PC             = 32'h100;
      upd_valid      = 1'b1;
      upd_PC         = 32'h180;
      upd_target     = 32'h777;
      upd_taken      = 1'b1;
      upd_mispredict = 1'b1;
      bp_clear       = 1'b0;
      #2;
      rst = 1'b0;
      model_reset();
      push_expect();
      @(posedge clk);
      #3;
      upd_valid = 1'b0;
      rst       = 1'b1;
      idle(32'h180);
      idle(32'h100);

      // Three updates, one flagged mispredict, then observe the counters
      cycle(32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
      cycle(32'h100, 1'b1, 32'h104, 32'h204, 1'b1, 1'b1, 1'b0);
      cycle(32'h100, 1'b1, 32'h108, 32'h208, 1'b0, 1'b0, 1'b0);
      idle(32'h104);

      random_cycles(200);

      @(posedge clk);
      #6;
      n_cmp++;
      if (sbq.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
